regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 86 ++++++++
 tb/tb_regfile_scoreboard.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending-write scoreboard (busy bits + busy count).
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] readRegister1,
  input  logic [ADDR_BITS-1:0] readRegister2,
  output logic [WIDTH-1:0]     readData1,
  output logic [WIDTH-1:0]     readData2,
  output logic                 readBusy1,
  output logic                 readBusy2,
  input  logic [ADDR_BITS-1:0] writeRegister,
  input  logic [WIDTH-1:0]     writeData,
  input  logic                 regWrite,
  input  logic [ADDR_BITS-1:0] reserveRegister,
  input  logic                 reserve,
  output logic                 reserveAccept,
  output logic [ADDR_BITS:0]   busyCount
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] CNT_ONE = (ADDR_BITS + 1)'(1);

  logic [WIDTH-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [ADDR_BITS:0] cnt_q, cnt_d;
  logic               wr_en;
  logic               busy_clr;

  assign wr_en         = regWrite && (writeRegister != '0);
  assign busy_clr      = wr_en && busy_q[writeRegister];
  assign reserveAccept = reserve && (reserveRegister != '0) && !busy_q[reserveRegister] && !reset;
  assign busyCount     = cnt_q;

  // An accepted reserve always targets an idle register and a clear always targets a
  // busy one, so both can never hit the same register; set-wins falls out naturally.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_clr) begin
      busy_d[writeRegister] = 1'b0;
      cnt_d                 = cnt_d - CNT_ONE;
    end
    if (reserveAccept) begin
      busy_d[reserveRegister] = 1'b1;
      cnt_d                   = cnt_d + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[writeRegister] <= writeData;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1, byp2;
  assign byp1      = wr_en && !reset && (writeRegister == readRegister1);
  assign byp2      = wr_en && !reset && (writeRegister == readRegister2);
  assign readData1 = byp1 ? writeData : regs_q[readRegister1];
  assign readData2 = byp2 ? writeData : regs_q[readRegister2];
  assign readBusy1 = byp1 ? 1'b0 : busy_q[readRegister1];
  assign readBusy2 = byp2 ? 1'b0 : busy_q[readRegister2];
`else
  assign readData1 = regs_q[readRegister1];
  assign readData2 = regs_q[readRegister2];
  assign readBusy1 = busy_q[readRegister1];
  assign readBusy2 = busy_q[readRegister2];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard; expected read data flows through a scoreboard queue.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  readRegister1, readRegister2, writeRegister, reserveRegister;
  logic [31:0] readData1, readData2, writeData;
  logic        readBusy1, readBusy2, regWrite, reserve, reserveAccept;
  logic [5:0]  busyCount;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .readData1(readData1), .readData2(readData2),
    .readBusy1(readBusy1), .readBusy2(readBusy2),
    .writeRegister(writeRegister), .writeData(writeData), .regWrite(regWrite),
    .reserveRegister(reserveRegister), .reserve(reserve),
    .reserveAccept(reserveAccept), .busyCount(busyCount)
  );

  always #5 clk = ~clk;

  // Advance to 1ns past the next rising edge, then drop one-shot requests.
  task automatic step();
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    reserve  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; regWrite = 1'b0; reserve = 1'b1; reserveRegister = 5'd3;
    writeRegister = '0; writeData = '0; readRegister1 = 5'd3; readRegister2 = 5'd0;
    #1;
    checks++;
    if (reserveAccept !== 1'b0) begin failures++; $display("FAIL reset_accept got=%b exp=0", reserveAccept); end
    step(); reserve = 1'b1; step(); reset = 1'b0; #1;
    checks++;
    if (readData1 !== 32'd0 || readData2 !== 32'd0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0", readData1, readData2);
    end
    checks++;
    if (readBusy1 !== 1'b0 || readBusy2 !== 1'b0 || busyCount !== 6'd0) begin
      failures++; $display("FAIL reset_busy got=%b/%b cnt=%0d exp=0", readBusy1, readBusy2, busyCount);
    end
  endtask

  task automatic test_write_read();
    regWrite = 1'b1; writeRegister = 5'd2; writeData = 32'd42; exp_q.push_back(32'd42);
    readRegister1 = 5'd2; readRegister2 = 5'd2;
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (readData1 !== exp_v || readData2 !== exp_v) begin
      failures++; $display("FAIL write_r2 got=%0d/%0d exp=%0d", readData1, readData2, exp_v);
    end
    regWrite = 1'b1; writeRegister = 5'd0; writeData = 32'd15; exp_q.push_back(32'd0);
    readRegister1 = 5'd0; readRegister2 = 5'd0;
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (readData1 !== exp_v || readData2 !== exp_v) begin
      failures++; $display("FAIL write_r0 got=%0d/%0d exp=%0d", readData1, readData2, exp_v);
    end
  endtask

  task automatic test_reserve();
    reserve = 1'b1; reserveRegister = 5'd5; readRegister1 = 5'd5; #1;
    checks++;
    if (reserveAccept !== 1'b1) begin failures++; $display("FAIL reserve_r5_accept got=%b exp=1", reserveAccept); end
    step();
    checks++;
    if (readBusy1 !== 1'b1 || busyCount !== 6'd1) begin
      failures++; $display("FAIL reserve_r5_busy got=%b cnt=%0d exp=1 cnt=1", readBusy1, busyCount);
    end
    reserve = 1'b1; reserveRegister = 5'd5; #1;
    checks++;
    if (reserveAccept !== 1'b0) begin failures++; $display("FAIL rereserve_accept got=%b exp=0", reserveAccept); end
    step();
    checks++;
    if (busyCount !== 6'd1) begin failures++; $display("FAIL rereserve_cnt got=%0d exp=1", busyCount); end
  endtask

  task automatic test_clear();
    regWrite = 1'b1; writeRegister = 5'd5; writeData = 32'd7; exp_q.push_back(32'd7);
    readRegister1 = 5'd5;
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (readBusy1 !== 1'b0 || busyCount !== 6'd0 || readData1 !== exp_v) begin
      failures++; $display("FAIL clear_r5 got busy=%b cnt=%0d data=%0d exp busy=0 cnt=0 data=%0d", readBusy1, busyCount, readData1, exp_v);
    end
    regWrite = 1'b1; writeRegister = 5'd6; writeData = 32'd9; exp_q.push_back(32'd9);
    readRegister2 = 5'd6;
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (busyCount !== 6'd0 || readData2 !== exp_v || readBusy2 !== 1'b0) begin
      failures++; $display("FAIL write_idle_r6 got cnt=%0d data=%0d exp cnt=0 data=%0d", busyCount, readData2, exp_v);
    end
  endtask

  task automatic test_same_cycle();
    reserve = 1'b1; reserveRegister = 5'd3;
    regWrite = 1'b1; writeRegister = 5'd3; writeData = 32'd11; exp_q.push_back(32'd11);
    readRegister1 = 5'd3; #1;
    checks++;
    if (reserveAccept !== 1'b1) begin failures++; $display("FAIL same_accept got=%b exp=1", reserveAccept); end
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (readBusy1 !== 1'b1 || readData1 !== exp_v || busyCount !== 6'd1) begin
      failures++; $display("FAIL same_r3 got busy=%b data=%0d cnt=%0d exp busy=1 data=%0d cnt=1", readBusy1, readData1, busyCount, exp_v);
    end
    reserve = 1'b1; reserveRegister = 5'd0; #1;
    checks++;
    if (reserveAccept !== 1'b0) begin failures++; $display("FAIL reserve_r0 got=%b exp=0", reserveAccept); end
    step();
    // Rejected reserve of a busy register plus a write to it: busy clears, no retry.
    reserve = 1'b1; reserveRegister = 5'd3;
    regWrite = 1'b1; writeRegister = 5'd3; writeData = 32'd12; exp_q.push_back(32'd12); #1;
    checks++;
    if (reserveAccept !== 1'b0) begin failures++; $display("FAIL reject_accept got=%b exp=0", reserveAccept); end
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (readBusy1 !== 1'b0 || readData1 !== exp_v || busyCount !== 6'd0) begin
      failures++; $display("FAIL reject_r3 got busy=%b data=%0d cnt=%0d exp busy=0 data=%0d cnt=0", readBusy1, readData1, busyCount, exp_v);
    end
  endtask

  task automatic test_fill_reset();
    for (int i = 1; i < 32; i++) begin
      reserve = 1'b1; reserveRegister = 5'(i);
      step();
    end
    checks++;
    if (busyCount !== 6'd31) begin failures++; $display("FAIL fill_cnt got=%0d exp=31", busyCount); end
    reset = 1'b1; regWrite = 1'b1; writeRegister = 5'd4; writeData = 32'd99; exp_q.push_back(32'd0);
    step();
    reset = 1'b0; #1;
    for (int i = 0; i < 32; i++) begin
      readRegister1 = 5'(i); #1;
      checks++;
      if (readBusy1 !== 1'b0) begin failures++; $display("FAIL reset_busy_r%0d got=%b exp=0", i, readBusy1); end
    end
    checks++;
    if (busyCount !== 6'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", busyCount); end
    readRegister1 = 5'd4; readRegister2 = 5'd2; #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (readData1 !== exp_v || readData2 !== 32'd0) begin
      failures++; $display("FAIL reset_data_r4 got=%0d r2=%0d exp=%0d", readData1, readData2, exp_v);
    end
  endtask

  task automatic test_bypass();
    step();
    regWrite = 1'b1; writeRegister = 5'd8; writeData = 32'h55; reserve = 1'b1; reserveRegister = 5'd8;
    step();
    regWrite = 1'b1; writeRegister = 5'd8; writeData = 32'h1234; readRegister1 = 5'd8;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'h1234);
`else
    exp_q.push_back(32'h55);
`endif
    exp_q.push_back(32'h1234);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (readData1 !== exp_v) begin failures++; $display("FAIL bypass_data got=%h exp=%h", readData1, exp_v); end
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (readBusy1 !== 1'b0) begin failures++; $display("FAIL bypass_busy got=%b exp=0", readBusy1); end
`else
    if (readBusy1 !== 1'b1) begin failures++; $display("FAIL bypass_busy got=%b exp=1", readBusy1); end
`endif
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (readData1 !== exp_v || readBusy1 !== 1'b0 || busyCount !== 6'd0) begin
      failures++; $display("FAIL post_edge_r8 got data=%h busy=%b cnt=%0d exp data=%h busy=0 cnt=0", readData1, readBusy1, busyCount, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reserve();
    test_clear();
    test_same_cycle();
    test_fill_reset();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
